// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: board/core-side signals of the run/step controller.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a plain level.
interface cpu_run_ctrl_if;
  logic       btn_run;
  logic       btn_step;
  logic       cpu_halt_req;
  logic       slow_clk;
  logic       halt;
  logic       running;
  logic       step_done;
  logic [1:0] state;

  // board / environment side: drives buttons, core request and divided clock
  modport master (
    output btn_run, btn_step, cpu_halt_req, slow_clk,
    input  halt, running, step_done, state
  );

  // controller side
  modport slave (
    input  btn_run, btn_step, cpu_halt_req, slow_clk,
    output halt, running, step_done, state
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/stop/single-step controller driving the clock divider's halt input.
// Latency: raw button edge -> event 2+DEBOUNCE_CYCLES cycles; event -> state/halt 1 cycle.
// Backpressure: none; inputs are levels, all outputs are registered.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit START_RUNNING   = 1'b0
) (
  input logic           clk,
  input logic           reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // button index 0 = run, 1 = step
  localparam int            NB       = 2;

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2,
    TRAPPED  = 2'd3
  } state_t;

  logic [NB-1:0] btn_meta;
  logic [NB-1:0] btn_sync;
  logic [NB-1:0] btn_acc;
  logic [NB-1:0] btn_evt;
  logic [CW-1:0] db_cnt [NB];
  logic [2:0]    slow_sync;
  logic          slow_rise;
  logic          run_evt;
  logic          step_evt;

  state_t        state_q;
  logic          halt_q;
  logic          running_q;
  logic          step_done_q;

  // two-flop synchronisers; slow_clk carries a third stage for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      slow_sync <= '0;
    end else begin
      btn_meta  <= {bus.btn_step, bus.btn_run};
      btn_sync  <= btn_meta;
      slow_sync <= {slow_sync[1:0], bus.slow_clk};
    end
  end

  assign slow_rise = slow_sync[1] & ~slow_sync[2];

  // debounce: the counter measures how long the synced level has disagreed with the
  // accepted one; any agreeing sample restarts it, and the flip clears it so it never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NB; i++) begin
        db_cnt[i] <= '0;
      end
      btn_acc <= '0;
      btn_evt <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        btn_evt[i] <= 1'b0;
        if (btn_sync[i] == btn_acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_cnt[i]  <= '0;
          btn_acc[i] <= btn_sync[i];
          // only a press (accepted 0->1) is an event; a release is silent
          btn_evt[i] <= btn_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign run_evt  = btn_evt[0];
  assign step_evt = btn_evt[1];

  // run/step state machine; halt/running are updated on the same edge as the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= START_RUNNING ? RUNNING : HALTED;
      halt_q      <= !START_RUNNING;
      running_q   <= START_RUNNING;
      step_done_q <= 1'b0;
    end else begin
      step_done_q <= 1'b0;
      unique case (state_q)
        HALTED: begin
          if (bus.cpu_halt_req) begin
            state_q   <= TRAPPED;
            halt_q    <= 1'b1;
            running_q <= 1'b0;
          end else if (run_evt) begin
            // run wins over a simultaneous step; the step is dropped
            state_q   <= RUNNING;
            halt_q    <= 1'b0;
            running_q <= 1'b1;
          end else if (step_evt) begin
            state_q   <= STEPPING;
            halt_q    <= 1'b0;
            running_q <= 1'b0;
          end
        end
        RUNNING: begin
          if (bus.cpu_halt_req) begin
            state_q   <= TRAPPED;
            halt_q    <= 1'b1;
            running_q <= 1'b0;
          end else if (run_evt) begin
            state_q   <= HALTED;
            halt_q    <= 1'b1;
            running_q <= 1'b0;
          end
        end
        STEPPING: begin
          if (bus.cpu_halt_req) begin
            state_q   <= TRAPPED;
            halt_q    <= 1'b1;
            running_q <= 1'b0;
          end else if (run_evt) begin
            state_q   <= RUNNING;
            halt_q    <= 1'b0;
            running_q <= 1'b1;
          end else if (slow_rise) begin
            // the divider holds slow_clk low once halted, so one rise is one CPU cycle
            state_q     <= HALTED;
            halt_q      <= 1'b1;
            running_q   <= 1'b0;
            step_done_q <= 1'b1;
          end
        end
        TRAPPED: begin
          if (run_evt && !bus.cpu_halt_req) begin
            state_q   <= HALTED;
            halt_q    <= 1'b1;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= HALTED;
          halt_q    <= 1'b1;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state     = state_q;
  assign bus.halt      = halt_q;
  assign bus.running   = running_q;
  assign bus.step_done = step_done_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed scenarios plus randomized buttons/halt requests against a model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_run_ctrl;

  localparam int D   = 4;
  localparam int DIV = 4;
  localparam int HL  = D + 2;

  logic clk;
  logic reset;
  cpu_run_ctrl_if bus();

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(D), .START_RUNNING(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_state;
  bit m_halt, m_running, m_done;
  bit m_run_evt, m_step_evt, m_acc_run, m_acc_step;
  bit run_h[$];
  bit step_h[$];
  bit slow_h[$];

  // model divider
  int dcnt;
  bit div_freeze;
  int slow_rises;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_state = 0; m_halt = 1'b1; m_running = 1'b0; m_done = 1'b0;
    m_run_evt = 1'b0; m_step_evt = 1'b0; m_acc_run = 1'b0; m_acc_step = 1'b0;
    run_h.delete(); step_h.delete(); slow_h.delete();
    for (int i = 0; i < HL; i++) begin
      run_h.push_back(1'b0); step_h.push_back(1'b0); slow_h.push_back(1'b0);
    end
  endtask

  // h[0] is the raw value seen at this edge; the design's synced copy lags by two,
  // so a flip needs samples 2..D+1 ago all different from the accepted level
  function automatic bit window_flip(input bit h[$], input bit acc);
    for (int i = 2; i <= D + 1; i++) begin
      if (h[i] == acc) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit sl, input bit req);
    bit rise, run_e, step_e;
    run_h.push_front(r);   void'(run_h.pop_back());
    step_h.push_front(s);  void'(step_h.pop_back());
    slow_h.push_front(sl); void'(slow_h.pop_back());
    rise   = slow_h[2] && !slow_h[3];
    run_e  = m_run_evt;
    step_e = m_step_evt;
    m_done = 1'b0;
    case (m_state)
      0: if (req) m_state = 3; else if (run_e) m_state = 1; else if (step_e) m_state = 2;
      1: if (req) m_state = 3; else if (run_e) m_state = 0;
      2: if (req) m_state = 3; else if (run_e) m_state = 1;
         else if (rise) begin m_state = 0; m_done = 1'b1; end
      default: if (run_e && !req) m_state = 0;
    endcase
    m_halt    = (m_state == 0) || (m_state == 3);
    m_running = (m_state == 1);
    m_run_evt = 1'b0;
    if (window_flip(run_h, m_acc_run)) begin
      m_acc_run = !m_acc_run; m_run_evt = m_acc_run;
    end
    m_step_evt = 1'b0;
    if (window_flip(step_h, m_acc_step)) begin
      m_acc_step = !m_acc_step; m_step_evt = m_acc_step;
    end
  endtask

  // one clock: model follows the edge, then the divider model reacts to halt
  task automatic cycle();
    bit r, s, sl, q;
    @(posedge clk);
    r = bus.btn_run; s = bus.btn_step; sl = bus.slow_clk; q = bus.cpu_halt_req;
    if (!reset) model_reset();
    else        model_step(r, s, sl, q);
    #1;
    if (bus.halt) begin
      bus.slow_clk = 1'b0; dcnt = 0;
    end else if (!div_freeze) begin
      if (dcnt == DIV - 1) begin
        dcnt = 0;
        bus.slow_clk = !bus.slow_clk;
        if (bus.slow_clk) slow_rises++;
      end else begin
        dcnt++;
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic press_run();
    bus.btn_run = 1'b1; cycles(D + 3);
    bus.btn_run = 1'b0; cycles(D + 3);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      cycle();
      checks++;
      if ({bus.state, bus.halt, bus.running, bus.step_done} !== 5'b00_1_0_0) begin
        failures++;
        $display("FAIL reset_hold: got %b expected 00100",
                 {bus.state, bus.halt, bus.running, bus.step_done});
      end
    end
    reset = 1'b1;
    cycle();
    checks++;
    if ({bus.state, bus.halt, bus.running, bus.step_done} !== 5'b00_1_0_0) begin
      failures++;
      $display("FAIL reset_release: got %b expected 00100",
               {bus.state, bus.halt, bus.running, bus.step_done});
    end
  endtask

  task automatic test_debounce();
    int n;
    for (int i = 0; i < 10; i++) begin
      bus.btn_run = (i % 2 == 0);
      repeat (2) begin
        cycle();
        checks++;
        if (bus.state !== 2'd0 || bus.halt !== 1'b1) begin
          failures++;
          $display("FAIL bounce_ignored: state=%0d halt=%0d expected state=0 halt=1",
                   bus.state, bus.halt);
        end
      end
    end
    bus.btn_run = 1'b1;
    n = 0;
    while (bus.state !== 2'd1 && n < 20) begin
      cycle(); n++;
    end
    checks++;
    if (n !== 7) begin
      failures++;
      $display("FAIL debounce_latency: got %0d cycles expected 7", n);
    end
    checks++;
    if (bus.halt !== 1'b0 || bus.running !== 1'b1) begin
      failures++;
      $display("FAIL run_outputs: halt=%0d running=%0d expected halt=0 running=1",
               bus.halt, bus.running);
    end
    cycles(10);
    bus.btn_run = 1'b0;
    cycles(D + 4);
    checks++;
    if (bus.state !== 2'd1) begin
      failures++;
      $display("FAIL release_no_event: state=%0d expected 1", bus.state);
    end
  endtask

  task automatic test_step();
    int n, done_cnt;
    press_run();
    checks++;
    if (bus.state !== 2'd0) begin
      failures++;
      $display("FAIL stop_to_halted: state=%0d expected 0", bus.state);
    end
    slow_rises = 0; done_cnt = 0; n = 0;
    bus.btn_step = 1'b1;
    while (bus.state !== 2'd2 && n < 20) begin
      cycle(); n++;
      if (bus.step_done === 1'b1) done_cnt++;
    end
    checks++;
    if (bus.state !== 2'd2 || bus.halt !== 1'b0) begin
      failures++;
      $display("FAIL step_enter: state=%0d halt=%0d expected state=2 halt=0",
               bus.state, bus.halt);
    end
    n = 0;
    while (bus.state !== 2'd0 && n < 40) begin
      cycle(); n++;
      if (bus.step_done === 1'b1) done_cnt++;
    end
    // button still held: no further step may start
    repeat (12) begin
      cycle();
      if (bus.step_done === 1'b1) done_cnt++;
    end
    checks++;
    if (bus.state !== 2'd0 || bus.halt !== 1'b1) begin
      failures++;
      $display("FAIL step_return: state=%0d halt=%0d expected state=0 halt=1",
               bus.state, bus.halt);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL step_done_count: got %0d expected 1", done_cnt);
    end
    checks++;
    if (slow_rises !== 1) begin
      failures++;
      $display("FAIL slow_rise_count: got %0d expected 1", slow_rises);
    end
    bus.btn_step = 1'b0;
    cycles(D + 4);
  endtask

  task automatic test_trap();
    press_run();
    checks++;
    if (bus.state !== 2'd1) begin
      failures++;
      $display("FAIL trap_setup: state=%0d expected 1", bus.state);
    end
    bus.cpu_halt_req = 1'b1;
    cycle();
    checks++;
    if (bus.state !== 2'd3 || bus.halt !== 1'b1) begin
      failures++;
      $display("FAIL trap_enter: state=%0d halt=%0d expected state=3 halt=1",
               bus.state, bus.halt);
    end
    press_run();
    checks++;
    if (bus.state !== 2'd3) begin
      failures++;
      $display("FAIL trap_hold: state=%0d expected 3", bus.state);
    end
    bus.cpu_halt_req = 1'b0;
    cycle();
    press_run();
    checks++;
    if (bus.state !== 2'd0 || bus.halt !== 1'b1) begin
      failures++;
      $display("FAIL trap_exit: state=%0d halt=%0d expected state=0 halt=1",
               bus.state, bus.halt);
    end
  endtask

  task automatic test_priority();
    int n;
    bus.btn_run = 1'b1; bus.btn_step = 1'b1;
    cycles(D + 3);
    checks++;
    if (bus.state !== 2'd1) begin
      failures++;
      $display("FAIL prio_run_over_step: state=%0d expected 1", bus.state);
    end
    bus.btn_run = 1'b0; bus.btn_step = 1'b0;
    cycles(D + 4);
    checks++;
    if (bus.state !== 2'd1) begin
      failures++;
      $display("FAIL step_not_queued: state=%0d expected 1", bus.state);
    end
    press_run();
    div_freeze = 1'b1;
    bus.btn_step = 1'b1; cycles(D + 3);
    bus.btn_step = 1'b0; cycles(D + 3);
    checks++;
    if (bus.state !== 2'd2) begin
      failures++;
      $display("FAIL step_frozen: state=%0d expected 2", bus.state);
    end
    bus.btn_run = 1'b1;
    n = 0;
    while (!m_run_evt && n < 20) begin
      cycle(); n++;
    end
    bus.cpu_halt_req = 1'b1;
    cycle();
    checks++;
    if (bus.state !== 2'd3) begin
      failures++;
      $display("FAIL prio_req_over_run: state=%0d expected 3", bus.state);
    end
    bus.btn_run = 1'b0; bus.cpu_halt_req = 1'b0;
    cycles(D + 3);
    press_run();
    div_freeze = 1'b0;
  endtask

  task automatic test_reset_mid_step();
    int done_cnt;
    done_cnt = 0;
    div_freeze = 1'b1;
    bus.btn_step = 1'b1;
    cycles(D + 3);
    checks++;
    if (bus.state !== 2'd2 || bus.halt !== 1'b0) begin
      failures++;
      $display("FAIL midstep_setup: state=%0d halt=%0d expected state=2 halt=0",
               bus.state, bus.halt);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.state, bus.halt, bus.running, bus.step_done} !== 5'b00_1_0_0) begin
      failures++;
      $display("FAIL async_reset_abort: got %b expected 00100",
               {bus.state, bus.halt, bus.running, bus.step_done});
    end
    bus.btn_step = 1'b0;
    div_freeze = 1'b0;
    repeat (2) begin
      cycle();
      if (bus.step_done === 1'b1) done_cnt++;
    end
    reset = 1'b1;
    repeat (D + 6) begin
      cycle();
      if (bus.step_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0 || bus.state !== 2'd0) begin
      failures++;
      $display("FAIL no_step_done_after_reset: pulses=%0d state=%0d expected 0 and 0",
               done_cnt, bus.state);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.btn_run  = !bus.btn_run;
      if ($urandom_range(0, 5) == 0) bus.btn_step = !bus.btn_step;
      if (bus.cpu_halt_req) begin
        if ($urandom_range(0, 9) == 0) bus.cpu_halt_req = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        bus.cpu_halt_req = 1'b1;
      end
      cycle();
      checks++;
      if ({bus.state, bus.halt, bus.running, bus.step_done} !==
          {2'(m_state), m_halt, m_running, m_done}) begin
        failures++;
        $display("FAIL random_cycle%0d: got %b expected %b", i,
                 {bus.state, bus.halt, bus.running, bus.step_done},
                 {2'(m_state), m_halt, m_running, m_done});
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.btn_run = 1'b0; bus.btn_step = 1'b0;
    bus.cpu_halt_req = 1'b0; bus.slow_clk = 1'b0;
    dcnt = 0; div_freeze = 1'b0; slow_rises = 0;
    model_reset();
    test_reset();
    test_debounce();
    test_step();
    test_trap();
    test_priority();
    test_reset_mid_step();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
